lcd_host_if: RTL and testbench
==============================

LCD_HOST_IF -- requirements
Module: lcd_host_if

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of entries in the upstream command queue (power of two, 2..16).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 up_valid  input  1  upstream command-offer strobe.
REQ-005 up_cmd  input  4  upstream command code; 0 = Write, 1..11 = controller operations.
REQ-006 up_ready  output  1  high when the queue accepts up_cmd this cycle.
REQ-007 busy  input  1  controller busy flag.
REQ-008 done  input  1  controller one-cycle frame-complete pulse.
REQ-009 cmd  output  4  command to the controller, registered.
REQ-010 cmd_valid  output  1  command strobe to the controller, registered.
REQ-011 IRAM_valid  input  1  controller pixel-write strobe.
REQ-012 IRAM_A  input  6  pixel write address.
REQ-013 IRAM_D  input  8  pixel write data.
REQ-014 rd_addr  input  6  frame-memory read address.
REQ-015 rd_data  output  8  frame-memory data at rd_addr, combinational.
REQ-016 wr_count  output  7  number of pixel writes captured.
REQ-017 frame_done  output  1  one-cycle pulse on frame completion.
REQ-018 cksum  output  16  pixel checksum, present only with LCD_HOST_CKSUM_EN.

Function
REQ-019 The block SHALL hold a FIFO_DEPTH-entry FIFO; a push occurs when up_valid and up_ready are both high.
REQ-020 up_ready SHALL equal (queue not full) AND (state is LOAD or ISSUE); it does not bypass a pop while full.
REQ-021 States SHALL be LOAD, ISSUE, WAIT_DONE and FIN; reset enters LOAD.
REQ-022 LOAD -> ISSUE on the first cycle with busy low; no command is issued in LOAD.
REQ-023 In ISSUE, when busy is low and the queue is non-empty: next cycle cmd_valid=1, cmd=head entry, head popped; one command is issued per cycle, back-to-back.
REQ-024 Otherwise cmd_valid SHALL be 0 and cmd SHALL be 4'hF (idle code; never 0, because the controller decodes Write from cmd alone).
REQ-025 Popping code 0 SHALL move the state to WAIT_DONE; no further pops occur until FIN or reset.
REQ-026 In WAIT_DONE, done high -> FIN, and frame_done SHALL pulse high in the following cycle for exactly one cycle.
REQ-027 FIN is terminal until reset: up_ready=0, cmd_valid=0, and queue contents are retained.
REQ-028 Codes 12..15 SHALL be forwarded verbatim as no-ops.
REQ-029 In any state, each cycle with IRAM_valid high SHALL write IRAM_D into the 64x8 frame memory at IRAM_A and increment wr_count.
REQ-030 wr_count SHALL saturate at 127.
REQ-031 Repeated writes to the same address SHALL overwrite the stored pixel and SHALL each be counted.
REQ-032 rd_data SHALL reflect a write in the cycle after that write.
REQ-033 Simultaneous push and pop SHALL leave the occupancy unchanged.

Reset
REQ-034 On reset: cmd=4'hF, cmd_valid=0, up_ready=0 (state LOAD, busy high), frame_done=0, wr_count=0, cksum=0, queue empty, state LOAD.
REQ-035 Reset asserted mid-frame SHALL abort immediately with the REQ-034 values.
REQ-036 Frame-memory contents are not reset.

Configuration
REQ-037 With LCD_HOST_CKSUM_EN defined: cksum SHALL add zero-extended IRAM_D on every IRAM_valid cycle, modulo 2^16.
REQ-038 Without LCD_HOST_CKSUM_EN: the cksum port and its adder SHALL be absent; all other behaviour is identical.

Verification
REQ-039 Hold busy high 10 cycles, then low, while pushing 1,5,0 -> no cmd_valid during load; then cmd_valid for 1,5,0 on 3 consecutive cycles; state WAIT_DONE.
REQ-040 Push 5 commands with busy low, controller stalled (busy high) -> up_ready drops after 4 pushes; 5th accepted only after first pop.
REQ-041 Controller writes IRAM_A=0..63 with IRAM_D=A then pulses done -> wr_count=64, rd_data(37)=37, frame_done one pulse one cycle after done, cksum=2016.
REQ-042 Push 0 then 3 -> only 0 issued; 3 never issued; after done, up_ready=0.
REQ-043 Assert reset during pixel 20 of a frame -> wr_count=0, cmd=4'hF, cmd_valid=0 next cycle; state LOAD.
REQ-044 Write address 7 twice, with values 8'hAA then 8'h55 -> rd_data(7)=8'h55, wr_count=2.

Source files
------------

// File: rtl/lcd_host_if_if.sv
// lcd_host_if_if: host, controller and frame-memory signals of lcd_host_if.
// cksum exists only when LCD_HOST_CKSUM_EN is defined.
interface lcd_host_if_if;
  logic up_valid;
  logic [3:0] up_cmd;
  logic up_ready;
  logic busy;
  logic done;
  logic [3:0] cmd;
  logic cmd_valid;
  logic IRAM_valid;
  logic [5:0] IRAM_A;
  logic [7:0] IRAM_D;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic [6:0] wr_count;
  logic frame_done;
`ifdef LCD_HOST_CKSUM_EN
  logic [15:0] cksum;
`endif
  modport master (
    output up_valid, up_cmd, busy, done, IRAM_valid, IRAM_A, IRAM_D, rd_addr,
    input up_ready, cmd, cmd_valid, rd_data, wr_count, frame_done
`ifdef LCD_HOST_CKSUM_EN
    , input cksum
`endif
  );
  modport slave (
    input up_valid, up_cmd, busy, done, IRAM_valid, IRAM_A, IRAM_D, rd_addr,
    output up_ready, cmd, cmd_valid, rd_data, wr_count, frame_done
`ifdef LCD_HOST_CKSUM_EN
    , output cksum
`endif
  );
endinterface

// File: rtl/lcd_host_if.sv
// lcd_host_if: queues host commands for an LCD controller and captures its pixel writes.
// Defining LCD_HOST_CKSUM_EN adds a 16-bit running pixel checksum.
module lcd_host_if #(
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  lcd_host_if_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {LOAD, ISSUE, WAIT_DONE, FIN} state_t;
  state_t state;
  logic [3:0] q [FIFO_DEPTH];
  logic [7:0] mem [64];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic push, pop;
  // count reaches FIFO_DEPTH (a power of two) exactly when its top bit sets
  assign bus.up_ready = ~reset & ~count[AW] & (state == LOAD || state == ISSUE);
  assign push = bus.up_valid & bus.up_ready;
  assign pop = state == ISSUE && !bus.busy && count != '0;
  assign bus.rd_data = mem[bus.rd_addr];
  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= bus.up_cmd;
    if (bus.IRAM_valid) mem[bus.IRAM_A] <= bus.IRAM_D;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      bus.cmd <= 4'hF;
      bus.cmd_valid <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.wr_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= push && !pop ? count + 1'b1 : pop && !push ? count - 1'b1 : count;
      // idle code is F because the controller treats cmd==0 as Write regardless of cmd_valid
      bus.cmd <= pop ? q[rd_ptr] : 4'hF;
      bus.cmd_valid <= pop;
      bus.frame_done <= state == WAIT_DONE && bus.done;
      bus.wr_count <= bus.wr_count + 7'(bus.IRAM_valid && bus.wr_count != 7'd127);
      state <= state == LOAD && !bus.busy ? ISSUE :
               pop && q[rd_ptr] == 4'h0 ? WAIT_DONE :
               state == WAIT_DONE && bus.done ? FIN : state;
    end
  end
`ifdef LCD_HOST_CKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) bus.cksum <= '0;
    else if (bus.IRAM_valid) bus.cksum <= bus.cksum + {8'h00, bus.IRAM_D};
  end
`endif
endmodule

// File: tb/tb_lcd_host_if.sv
// tb_lcd_host_if: directed self-checking bench for lcd_host_if.
module tb_lcd_host_if;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int fails = 0;
  lcd_host_if_if bus();
  lcd_host_if #(.FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    bus.up_valid = 1'b0;
    bus.up_cmd = 4'h0;
    bus.busy = 1'b1;
    bus.done = 1'b0;
    bus.IRAM_valid = 1'b0;
    bus.IRAM_A = 6'd0;
    bus.IRAM_D = 8'd0;
    bus.rd_addr = 6'd0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    reset = 1'b1;
    step(1);
    checks++; if (bus.cmd !== 4'hF) begin fails++; $display("FAIL reset_cmd got %0h exp f", bus.cmd); end
    checks++; if (bus.cmd_valid !== 1'b0) begin fails++; $display("FAIL reset_cmd_valid got %0b exp 0", bus.cmd_valid); end
    checks++; if (bus.up_ready !== 1'b0) begin fails++; $display("FAIL reset_up_ready got %0b exp 0", bus.up_ready); end
    checks++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %0b exp 0", bus.frame_done); end
    checks++; if (bus.wr_count !== 7'd0) begin fails++; $display("FAIL reset_wr_count got %0d exp 0", bus.wr_count); end
`ifdef LCD_HOST_CKSUM_EN
    checks++; if (bus.cksum !== 16'd0) begin fails++; $display("FAIL reset_cksum got %0d exp 0", bus.cksum); end
`endif
    reset = 1'b0;
    #1;
    checks++; if (bus.up_ready !== 1'b1) begin fails++; $display("FAIL load_up_ready got %0b exp 1", bus.up_ready); end
  endtask

  task automatic test_load_issue;
    logic [3:0] codes [3];
    codes = '{4'd1, 4'd5, 4'd0};
    do_reset;
    for (int i = 0; i < 10; i++) begin
      bus.up_valid = i < 3;
      bus.up_cmd = codes[i % 3];
      step(1);
      checks++; if (bus.cmd_valid !== 1'b0) begin fails++; $display("FAIL load_no_issue cycle %0d got %0b exp 0", i, bus.cmd_valid); end
    end
    bus.busy = 1'b0;
    step(1);
    checks++; if (bus.cmd_valid !== 1'b0) begin fails++; $display("FAIL load_exit_no_issue got %0b exp 0", bus.cmd_valid); end
    for (int j = 0; j < 3; j++) begin
      step(1);
      checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd !== codes[j]) begin fails++; $display("FAIL issue_%0d got v=%0b cmd=%0h exp v=1 cmd=%0h", j, bus.cmd_valid, bus.cmd, codes[j]); end
    end
    step(1);
    checks++; if (bus.cmd_valid !== 1'b0 || bus.cmd !== 4'hF) begin fails++; $display("FAIL wait_idle got v=%0b cmd=%0h exp v=0 cmd=f", bus.cmd_valid, bus.cmd); end
    checks++; if (bus.up_ready !== 1'b0) begin fails++; $display("FAIL wait_up_ready got %0b exp 0", bus.up_ready); end
  endtask

  task automatic test_frame;
    do_reset;
    bus.busy = 1'b0;
    bus.up_valid = 1'b1;
    bus.up_cmd = 4'h0;
    step(1);
    bus.up_valid = 1'b0;
    step(1);
    checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd !== 4'h0) begin fails++; $display("FAIL frame_write_cmd got v=%0b cmd=%0h exp v=1 cmd=0", bus.cmd_valid, bus.cmd); end
    for (int a = 0; a < 64; a++) begin
      bus.IRAM_valid = 1'b1;
      bus.IRAM_A = 6'(a);
      bus.IRAM_D = 8'(a);
      step(1);
    end
    bus.IRAM_valid = 1'b0;
    bus.rd_addr = 6'd37;
    #1;
    checks++; if (bus.rd_data !== 8'd37) begin fails++; $display("FAIL frame_rd37 got %0d exp 37", bus.rd_data); end
    checks++; if (bus.wr_count !== 7'd64) begin fails++; $display("FAIL frame_wr_count got %0d exp 64", bus.wr_count); end
    checks++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL frame_done_early got %0b exp 0", bus.frame_done); end
`ifdef LCD_HOST_CKSUM_EN
    checks++; if (bus.cksum !== 16'd2016) begin fails++; $display("FAIL frame_cksum got %0d exp 2016", bus.cksum); end
`endif
    bus.rd_addr = 6'd63;
    #1;
    checks++; if (bus.rd_data !== 8'd63) begin fails++; $display("FAIL frame_rd63 got %0d exp 63", bus.rd_data); end
    bus.done = 1'b1;
    step(1);
    bus.done = 1'b0;
    checks++; if (bus.frame_done !== 1'b1) begin fails++; $display("FAIL frame_done_pulse got %0b exp 1", bus.frame_done); end
    step(1);
    checks++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL frame_done_width got %0b exp 0", bus.frame_done); end
    checks++; if (bus.up_ready !== 1'b0) begin fails++; $display("FAIL fin_up_ready got %0b exp 0", bus.up_ready); end
  endtask

  task automatic test_backpressure;
    logic [3:0] codes [5];
    codes = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6};
    do_reset;
    bus.busy = 1'b0;
    step(1);
    bus.busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.up_valid = 1'b1;
      bus.up_cmd = codes[i];
      #1;
      checks++; if (bus.up_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_%0d got %0b exp 1", i, bus.up_ready); end
      step(1);
    end
    bus.up_cmd = codes[4];
    #1;
    checks++; if (bus.up_ready !== 1'b0) begin fails++; $display("FAIL bp_full got %0b exp 0", bus.up_ready); end
    step(1);
    bus.busy = 1'b0;
    #1;
    checks++; if (bus.up_ready !== 1'b0) begin fails++; $display("FAIL bp_no_bypass got %0b exp 0", bus.up_ready); end
    step(1);
    checks++; if (bus.up_ready !== 1'b1) begin fails++; $display("FAIL bp_after_pop got %0b exp 1", bus.up_ready); end
    for (int j = 0; j < 5; j++) begin
      checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd !== codes[j]) begin fails++; $display("FAIL bp_issue_%0d got v=%0b cmd=%0h exp v=1 cmd=%0h", j, bus.cmd_valid, bus.cmd, codes[j]); end
      step(1);
      bus.up_valid = 1'b0;
    end
    checks++; if (bus.cmd_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got %0b exp 0", bus.cmd_valid); end
  endtask

  task automatic test_write_stops;
    do_reset;
    bus.busy = 1'b0;
    bus.up_valid = 1'b1;
    bus.up_cmd = 4'd0;
    step(1);
    bus.up_cmd = 4'd3;
    step(1);
    bus.up_valid = 1'b0;
    checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd !== 4'd0) begin fails++; $display("FAIL stop_write got v=%0b cmd=%0h exp v=1 cmd=0", bus.cmd_valid, bus.cmd); end
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++; if (bus.cmd_valid !== 1'b0 || bus.cmd !== 4'hF) begin fails++; $display("FAIL stop_no_issue_%0d got v=%0b cmd=%0h exp v=0 cmd=f", i, bus.cmd_valid, bus.cmd); end
    end
    bus.done = 1'b1;
    step(1);
    bus.done = 1'b0;
    checks++; if (bus.frame_done !== 1'b1) begin fails++; $display("FAIL stop_frame_done got %0b exp 1", bus.frame_done); end
    step(2);
    checks++; if (bus.up_ready !== 1'b0 || bus.cmd_valid !== 1'b0) begin fails++; $display("FAIL stop_fin got ready=%0b v=%0b exp 0 0", bus.up_ready, bus.cmd_valid); end
  endtask

  task automatic test_noop;
    do_reset;
    bus.busy = 1'b0;
    bus.up_valid = 1'b1;
    bus.up_cmd = 4'd12;
    step(1);
    bus.up_cmd = 4'd15;
    step(1);
    bus.up_valid = 1'b0;
    checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd !== 4'd12) begin fails++; $display("FAIL noop_12 got v=%0b cmd=%0h exp v=1 cmd=c", bus.cmd_valid, bus.cmd); end
    step(1);
    checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd !== 4'd15) begin fails++; $display("FAIL noop_15 got v=%0b cmd=%0h exp v=1 cmd=f", bus.cmd_valid, bus.cmd); end
    step(1);
    checks++; if (bus.cmd_valid !== 1'b0 || bus.up_ready !== 1'b1) begin fails++; $display("FAIL noop_after got v=%0b ready=%0b exp 0 1", bus.cmd_valid, bus.up_ready); end
  endtask

  task automatic test_reset_mid_frame;
    do_reset;
    bus.busy = 1'b0;
    bus.up_valid = 1'b1;
    bus.up_cmd = 4'd0;
    step(1);
    bus.up_valid = 1'b0;
    step(1);
    for (int p = 1; p <= 20; p++) begin
      bus.IRAM_valid = 1'b1;
      bus.IRAM_A = 6'(p);
      bus.IRAM_D = 8'(p);
      if (p == 20) reset = 1'b1;
      step(1);
    end
    checks++; if (bus.wr_count !== 7'd0) begin fails++; $display("FAIL midrst_wr_count got %0d exp 0", bus.wr_count); end
    checks++; if (bus.cmd !== 4'hF || bus.cmd_valid !== 1'b0) begin fails++; $display("FAIL midrst_cmd got v=%0b cmd=%0h exp v=0 cmd=f", bus.cmd_valid, bus.cmd); end
    reset = 1'b0;
    bus.IRAM_valid = 1'b0;
    bus.busy = 1'b1;
    step(1);
    checks++; if (bus.up_ready !== 1'b1 || bus.cmd_valid !== 1'b0) begin fails++; $display("FAIL midrst_load got ready=%0b v=%0b exp 1 0", bus.up_ready, bus.cmd_valid); end
  endtask

  task automatic test_overwrite;
    do_reset;
    bus.IRAM_valid = 1'b1;
    bus.IRAM_A = 6'd7;
    bus.IRAM_D = 8'hAA;
    bus.rd_addr = 6'd7;
    step(1);
    checks++; if (bus.rd_data !== 8'hAA) begin fails++; $display("FAIL ow_first got %0h exp aa", bus.rd_data); end
    bus.IRAM_D = 8'h55;
    step(1);
    bus.IRAM_valid = 1'b0;
    checks++; if (bus.rd_data !== 8'h55) begin fails++; $display("FAIL ow_second got %0h exp 55", bus.rd_data); end
    checks++; if (bus.wr_count !== 7'd2) begin fails++; $display("FAIL ow_wr_count got %0d exp 2", bus.wr_count); end
    do_reset;
    bus.rd_addr = 6'd7;
    #1;
    checks++; if (bus.rd_data !== 8'h55) begin fails++; $display("FAIL mem_kept got %0h exp 55", bus.rd_data); end
  endtask

  task automatic test_saturate;
    do_reset;
    bus.IRAM_valid = 1'b1;
    step(126);
    checks++; if (bus.wr_count !== 7'd126) begin fails++; $display("FAIL sat_126 got %0d exp 126", bus.wr_count); end
    step(4);
    bus.IRAM_valid = 1'b0;
    checks++; if (bus.wr_count !== 7'd127) begin fails++; $display("FAIL sat_127 got %0d exp 127", bus.wr_count); end
  endtask

  initial begin
    test_reset;
    test_load_issue;
    test_frame;
    test_backpressure;
    test_write_stops;
    test_noop;
    test_reset_mid_frame;
    test_overwrite;
    test_saturate;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
